prog_clkdiv: RTL and testbench

- Multi-channel, runtime-programmable clock divider and tick generator. Next generation of the board-level fixed-divisor divider.
- Each channel produces a divided square-wave enable (clock_out) and a single-cycle period-start strobe (tick) from the FPGA input clock.
- Feeds display refresh, debouncers and slow counters.
- Divisors are reprogrammed through a valid/ready config port. Updates apply glitch-free at the next period boundary.

---
 rtl/clkdiv_pkg.sv | 23 ++
 rtl/clkdiv_ch.sv | 84 ++++++++
 rtl/prog_clkdiv.sv | 83 ++++++++
 tb/tb_prog_clkdiv.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants and width helpers for the programmable clock divider.
package clkdiv_pkg;

  localparam int MIN_DIV         = 2;
  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_DIV_W       = 28;
  localparam int DEF_DEFAULT_DIV = 400000;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

  // A single channel still needs a one-bit select so out-of-range writes stay encodable.
  function automatic int chWidth(input int numCh);
    return (clog2(numCh) < 1) ? 1 : clog2(numCh);
  endfunction

endpackage

// File: rtl/clkdiv_ch.sv
// One divider channel: period counter, shadow divisor with pending flag, registered outputs.
module clkdiv_ch
  import clkdiv_pkg::*;
#(
  parameter int DIV_W       = DEF_DIV_W,
  parameter int DEFAULT_DIV = DEF_DEFAULT_DIV
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_div_i,
  output logic             clock_out_o,
  output logic             tick_o,
  output logic             pending_o
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             clock_out_q, clock_out_d;
  logic             tick_q, tick_d;
  logic             wrap;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q       <= DEF_DIV - ONE;
      div_q       <= DEF_DIV;
      shadow_q    <= DEF_DIV;
      pending_q   <= 1'b0;
      clock_out_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      clock_out_q <= clock_out_d;
      tick_q      <= tick_d;
    end
  end

  // Outputs decode the counter's next value so they line up with the period it starts.
  always_comb begin
    cnt_d       = cnt_q;
    div_d       = div_q;
    shadow_d    = shadow_q;
    pending_d   = pending_q;
    clock_out_d = 1'b0;
    tick_d      = 1'b0;
    wrap        = 1'b0;
    if (!en_i) begin
      cnt_d = div_q - ONE;
    end else begin
      wrap = sync_i || (cnt_q == div_q - ONE);
      if (wrap) begin
        cnt_d = '0;
        if (pending_q) begin
          div_d     = shadow_q;
          pending_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + ONE;
      end
      clock_out_d = (cnt_d < (div_d >> 1));
      tick_d      = (cnt_d == '0);
    end
    // A load is only possible while nothing is pending, so it never collides with an apply.
    if (load_i) begin
      shadow_d  = load_div_i;
      pending_d = 1'b1;
    end
  end

  assign clock_out_o = clock_out_q;
  assign tick_o      = tick_q;
  assign pending_o   = pending_q;

endmodule

// File: rtl/prog_clkdiv.sv
// Multi-channel runtime-programmable clock divider / tick generator.
// Define CLKDIV_SYNC_EN to make sync_restart phase-align all enabled channels.
module prog_clkdiv
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int DEFAULT_DIV = DEF_DEFAULT_DIV,
  localparam int CH_W       = chWidth(NUM_CH)
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              sync_restart,
  output logic [NUM_CH-1:0] clock_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  logic [NUM_CH-1:0] loadStrobe;
  logic [DIV_W-1:0]  cfgDivClamped;
  logic              syncWrap;

  assign cfgDivClamped = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;

  // Selects that match no channel are always ready and simply dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = !pending[i];
      end
    end
  end

  always_comb begin
    loadStrobe = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      loadStrobe[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
    end
  end

`ifdef CLKDIV_SYNC_EN
  logic sync_q;

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      sync_q <= 1'b0;
    end else begin
      sync_q <= sync_restart;
    end
  end

  assign syncWrap = sync_q;
`else
  logic unused_sync;

  assign unused_sync = sync_restart;
  assign syncWrap    = 1'b0;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : gCh
    clkdiv_ch #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) uCh (
      .clk_i       (clock_in),
      .rst_ni      (reset_n),
      .en_i        (ch_en[g]),
      .sync_i      (syncWrap),
      .load_i      (loadStrobe[g]),
      .load_div_i  (cfgDivClamped),
      .clock_out_o (clock_out[g]),
      .tick_o      (tick[g]),
      .pending_o   (pending[g])
    );
  end

endmodule

// File: tb/tb_prog_clkdiv.sv
// Self-checking bench for prog_clkdiv: period-level model plus directed pattern checks.
// Honours CLKDIV_SYNC_EN so the model matches whichever build is compiled.
module tb_prog_clkdiv;

  localparam int NCH = 3;
  localparam int DW  = 8;
  localparam int DEF = 4;
`ifdef CLKDIV_SYNC_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif

  logic           clock_in = 1'b0;
  logic           reset_n;
  logic [NCH-1:0] ch_en;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_ch;
  logic [DW-1:0]  cfg_div;
  logic           sync_restart;
  logic [NCH-1:0] clock_out;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] pending;

  int checks = 0;
  int errors = 0;

  prog_clkdiv #(
    .NUM_CH      (NCH),
    .DIV_W       (DW),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clock_in     (clock_in),
    .reset_n      (reset_n),
    .ch_en        (ch_en),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_ch       (cfg_ch),
    .cfg_div      (cfg_div),
    .sync_restart (sync_restart),
    .clock_out    (clock_out),
    .tick         (tick),
    .pending      (pending)
  );

  always #5 clock_in = ~clock_in;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock_in);
      #2;
    end
  endtask

  // Model: each channel is a position within its current period, measured in cycles.
  int mdiv[NCH];
  int mpos[NCH];
  int mshadow[NCH];
  bit mrun[NCH];
  bit mpend[NCH];
  bit syncPrev;
  bit modelValid = 1'b0;
  logic [NCH-1:0] expClk;
  logic [NCH-1:0] expTick;
  int cfgSel;
  bit accept;

  always @(posedge clock_in) begin
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        mdiv[c] = DEF; mpos[c] = 0; mshadow[c] = DEF; mrun[c] = 0; mpend[c] = 0;
      end
      expClk = '0; expTick = '0; syncPrev = 0;
    end else begin
      cfgSel = int'(cfg_ch);
      accept = cfg_valid && ((cfgSel >= NCH) || !mpend[cfgSel]);
      for (int c = 0; c < NCH; c++) begin
        if (!ch_en[c]) begin
          mrun[c] = 0; expClk[c] = 0; expTick[c] = 0;
        end else begin
          if (!mrun[c] || (mpos[c] + 1 == mdiv[c]) || syncPrev) begin
            if (mpend[c]) begin
              mdiv[c] = mshadow[c]; mpend[c] = 0;
            end
            mpos[c] = 0; mrun[c] = 1;
          end else begin
            mpos[c]++;
          end
          expClk[c]  = (mpos[c] < mdiv[c] / 2);
          expTick[c] = (mpos[c] == 0);
        end
      end
      if (accept && cfgSel < NCH) begin
        mshadow[cfgSel] = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
        mpend[cfgSel]   = 1;
      end
      syncPrev = SYNC_ON ? sync_restart : 1'b0;
    end
    modelValid = 1'b1;
  end

  // Compare every cycle, half a period after the edge the model just evaluated.
  always @(negedge clock_in) begin
    if (modelValid) begin
      logic [NCH-1:0] expPend;
      logic expReady;
      for (int c = 0; c < NCH; c++) expPend[c] = mpend[c];
      expReady = (int'(cfg_ch) >= NCH) ? 1'b1 : !mpend[int'(cfg_ch)];
      checkOutput("model clock_out", 32'(clock_out), 32'(expClk));
      checkOutput("model tick", 32'(tick), 32'(expTick));
      checkOutput("model pending", 32'(pending), 32'(expPend));
      checkOutput("model cfg_ready", 32'(cfg_ready), 32'(expReady));
    end
  end

  task automatic recordCh(input int ch, input int n, output logic [15:0] clkPat, output logic [15:0] tickPat);
    clkPat = '0; tickPat = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) applyStimulus(1);
      clkPat  = {clkPat[14:0], clock_out[ch]};
      tickPat = {tickPat[14:0], tick[ch]};
    end
  endtask

  task automatic waitTick0(input string name);
    int n = 0;
    while (tick[0] !== 1'b1 && n < 16) begin
      applyStimulus(1);
      n++;
    end
    checkOutput(name, 32'(tick[0]), 32'd1);
  endtask

  task automatic waitPendClear(input int ch, input string name);
    int n = 0;
    while (pending[ch] !== 1'b0 && n < 16) begin
      applyStimulus(1);
      n++;
    end
    checkOutput(name, 32'(pending[ch]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] cp, tp;
    reset_n = 0; ch_en = '0; cfg_valid = 0; cfg_ch = '0; cfg_div = '0; sync_restart = 0;
    applyStimulus(3);
    checkOutput("reset clock_out", 32'(clock_out), 32'd0);
    checkOutput("reset tick", 32'(tick), 32'd0);
    checkOutput("reset pending", 32'(pending), 32'd0);

    // Release with all channels enabled: div 4 gives 1100 / 1000 from the first cycle.
    reset_n = 1; ch_en = 3'b111;
    applyStimulus(1);
    recordCh(0, 8, cp, tp);
    checkOutput("release clk0 pattern", 32'(cp), 32'b11001100);
    checkOutput("release tick0 pattern", 32'(tp), 32'b10001000);

    // Mid-period write of 5 to ch0; applies at the next wrap.
    applyStimulus(2);
    cfg_valid = 1; cfg_ch = 2'd0; cfg_div = 8'd5;
    checkOutput("ready before write", 32'(cfg_ready), 32'd1);
    applyStimulus(1);
    cfg_valid = 0;
    checkOutput("pending0 after write", 32'(pending[0]), 32'd1);
    checkOutput("ready0 while pending", 32'(cfg_ready), 32'd0);
    applyStimulus(2);
    recordCh(0, 10, cp, tp);
    checkOutput("div5 clk0 pattern", 32'(cp), 32'b1100011000);
    checkOutput("div5 tick0 pattern", 32'(tp), 32'b1000010000);

    // Divisor 0 on ch1 clamps to 2.
    cfg_valid = 1; cfg_ch = 2'd1; cfg_div = 8'd0;
    applyStimulus(1);
    cfg_valid = 0;
    waitPendClear(1, "ch1 apply timeout");
    recordCh(1, 6, cp, tp);
    checkOutput("div0 clk1 pattern", 32'(cp), 32'b101010);
    checkOutput("div0 tick1 pattern", 32'(tp), 32'b101010);

    // Out-of-range channel: accepted, discarded.
    cfg_valid = 1; cfg_ch = 2'd3; cfg_div = 8'd7;
    checkOutput("ready ch3", 32'(cfg_ready), 32'd1);
    applyStimulus(1);
    cfg_valid = 0; cfg_ch = 2'd0;
    checkOutput("pending after ch3", 32'(pending), 32'd0);

    // Transfer on ch0's wrap edge: one more div-5 period, then div 6.
    waitTick0("tick0 wait A");
    applyStimulus(4);
    cfg_valid = 1; cfg_ch = 2'd0; cfg_div = 8'd6;
    applyStimulus(1);
    cfg_valid = 0;
    checkOutput("pending0 on wrap write", 32'(pending[0]), 32'd1);
    recordCh(0, 11, cp, tp);
    checkOutput("wrap write clk0 pattern", 32'(cp), 32'b11000111000);
    checkOutput("wrap write tick0 pattern", 32'(tp), 32'b10000100000);

    // Disable ch0 mid-period for three cycles, then re-enable.
    waitTick0("tick0 wait B");
    applyStimulus(2);
    ch_en = 3'b110;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput("disabled clk0", 32'(clock_out[0]), 32'd0);
      checkOutput("disabled tick0", 32'(tick[0]), 32'd0);
    end
    ch_en = 3'b111;
    applyStimulus(1);
    checkOutput("reenable clk0", 32'(clock_out[0]), 32'd1);
    checkOutput("reenable tick0", 32'(tick[0]), 32'd1);

    // Mid-period reset: outputs clear on the next edge and div returns to 4.
    applyStimulus(2);
    reset_n = 0;
    applyStimulus(1);
    checkOutput("midreset clock_out", 32'(clock_out), 32'd0);
    checkOutput("midreset tick", 32'(tick), 32'd0);
    reset_n = 1;
    applyStimulus(1);
    recordCh(0, 8, cp, tp);
    checkOutput("post reset clk0 pattern", 32'(cp), 32'b11001100);

    // Put ch1 at div 6, skew it against ch0/ch2, then pulse sync_restart.
    cfg_valid = 1; cfg_ch = 2'd1; cfg_div = 8'd6;
    applyStimulus(1);
    cfg_valid = 0; cfg_ch = 2'd0;
    waitPendClear(1, "ch1 div6 timeout");
    applyStimulus(5);
    sync_restart = 1;
    applyStimulus(1);
    sync_restart = 0;
    applyStimulus(1);
    checkOutput("sync tick align", 32'(tick), SYNC_ON ? 32'b111 : 32'b000);
    applyStimulus(14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
